i2s_sample_tx: RTL
==================

// Module: i2s_sample_tx
// PURPOSE
//  Sink end of the oscillator step/sample interface: issues the one-cycle sample strobe to a
//  generator and latches its signed 32-bit sample. Serialises it as a standard Philips I2S
//  stereo frame (same word on L and R) to the board DAC. It sits between the voice/mixer
//  output and the DAC pins, and is the sample-rate master for the whole synth.
// PARAMETERS
//  CLK_DIV  4   clk_in cycles per sclk half-period; legal range >=1
//  OUT_W    24  DAC word width, MSB-aligned in 32-bit slot; legal range 16..32
// PORTS
//  clk_in     in   1   system clock; only clock in the block
//  rst_in     in   1   asynchronous, active-high reset
//  sample_in  in   32  signed sample from generator/mixer (amp_out of upstream)
//  step_out   out  1   one-clk strobe to upstream step_in; once per frame
//  sclk_out   out  1   I2S bit clock
//  lrclk_out  out  1   I2S word select; 0 = left, 1 = right
//  sdata_out  out  1   I2S serial data, MSB first
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): sclk_out=0, lrclk_out=0, sdata_out=0, step_out=0.
//    Divider, bit index and hold/shift registers are all cleared to 0. The frame restarts from
//    scratch after release; no partial word is resumed.
//  - Divider: counts 0..CLK_DIV-1 and toggles sclk_out on terminal count, so the sclk period is
//    2*CLK_DIV clk cycles. The first sclk edge after release is rising, at CLK_DIV cycles.
//  - All output changes (lrclk_out, sdata_out) occur in the clk cycle sclk_out falls.
//  - Frame = 64 sclk periods, index n=0..63. The first falling edge after reset starts n=0;
//    n wraps 63->0.
//  - lrclk_out = 0 for n=0..31 and 1 for n=32..63.
//  - sdata_out (standard I2S, one-bit delay):
//      n=0              last bit of previous right slot (0 after reset)
//      n=1..OUT_W       left word bits [OUT_W-1]..[0]
//      n=OUT_W+1..32    0 (padding)
//      n=33..32+OUT_W   right word, MSB first
//      n=33+OUT_W..63   0
//  - step_out: high for exactly one clk cycle, in the cycle n becomes 0 (every falling edge
//    starting a frame). This includes the first frame after reset.
//  - sample_in is registered into the hold register in that same cycle. The value captured is
//    therefore the sample from the previous step (one-frame latency). That word is transmitted
//    from n=1 of the current frame, on both slots.
//  - Word = sample_in[31 -: OUT_W] (truncation), except as set by CONFIGURATION.
//  - Frame period = 128*CLK_DIV clk cycles. step_out spacing is exactly this, with no jitter.
//  - sample_in is only sampled on the step_out cycle; changes at other times have no effect.
//  - CLK_DIV<1 or OUT_W outside 16..32: elaboration-time $error.
// CONFIGURATION
//  I2S_TX_ROUND_EN defined:
//    - Word = sat(sample_in + 2^(31-OUT_W)) >> (32-OUT_W), i.e. round half up.
//    - A positive overflow saturates to the max positive OUT_W word, 0111...1.
//    - For OUT_W=32 this is a pass-through.
//    - Adds one register stage inside the capture path; external timing is unchanged
//      (still loaded by n=1).
//  I2S_TX_ROUND_EN undefined:
//    - Plain truncation, as in BEHAVIOUR.
// STRUCTURE
//  - Shared package synth_pkg holds: typedef logic signed [31:0] sample_t; localparam
//    I2S_SLOT_W=32; localparam I2S_FRAME_BITS=64.
//  - Sub-module i2s_clk_div holds the divider. It produces sclk and single-cycle
//    sclk_rise/sclk_fall strobes, with async reset.
//  - Top holds the bit index counter, hold register, 64-bit frame shift register and the
//    step_out logic.
// TESTING
//  1 Reset release, CLK_DIV=2 -> sclk first rises at clk 2. step_out pulses at clk 4, then
//    every 256 clks. lrclk/sdata stay 0 before clk 4.
//  2 sample_in=32'h7FFF_FF80, OUT_W=24 -> left slot n=1..24 carries 0x7FFFFF MSB first, then
//    n=25..32 carry 0. Right slot is identical, offset 32. The word appears in the frame whose
//    step_out captured it.
//  3 sample_in=32'h8000_0000 -> word 0x800000. sdata=1 at n=1 and n=33, 0 elsewhere;
//    lrclk toggles at n=0 and n=32.
//  4 Toggle sample_in every clk -> only the value present on the step_out cycle is transmitted.
//  5 Assert rst_in at n=40 for 1 clk -> all outputs 0 immediately (asynchronous). The frame
//    restarts and step_out returns 2*CLK_DIV clks after release.
//  6 With I2S_TX_ROUND_EN, OUT_W=24: 32'h0000_0080 -> 0x000001. 32'h7FFF_FFF0 -> 0x7FFFFF
//    (saturated). Without the macro, 32'h0000_0080 -> 0x000000.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared synth types and I2S frame geometry
package synth_pkg;
  typedef logic signed [31:0] sample_t;
  localparam int I2S_SLOT_W     = 32;
  localparam int I2S_FRAME_BITS = 64;
endpackage

// File: rtl/i2s_clk_div.sv
// rtl/i2s_clk_div.sv - sclk divider with single-cycle rise/fall strobes
module i2s_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc = (cnt == CW'(CLK_DIV - 1));

  // Strobes are combinational so the consumer acts in the same clk as the sclk edge.
  assign sclk_rise = tc & ~sclk;
  assign sclk_fall = tc & sclk;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tc) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/i2s_sample_tx.sv
// rtl/i2s_sample_tx.sv - sample-rate master: steps upstream, sends Philips I2S stereo frames
// Optional rounding/saturation of the captured sample under I2S_TX_ROUND_EN.
module i2s_sample_tx
  import synth_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int OUT_W   = 24
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  sample_t sample_in,
  output logic    step_out,
  output logic    sclk_out,
  output logic    lrclk_out,
  output logic    sdata_out
);
  localparam int IDX_W = $clog2(I2S_FRAME_BITS);

  if (CLK_DIV < 1 || OUT_W < 16 || OUT_W > 32) begin : g_param_check
    $error("i2s_sample_tx: CLK_DIV must be >=1 and OUT_W within 16..32");
  end

  logic                      sclk_rise;
  logic                      sclk_fall;
  logic [IDX_W-1:0]          bit_idx;
  sample_t                   hold;
  logic [OUT_W-1:0]          word;
  logic [I2S_SLOT_W-1:0]     slot;
  logic [I2S_FRAME_BITS-1:0] frame;
  logic [I2S_FRAME_BITS-1:0] shreg;

  i2s_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .sclk      (sclk_out),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

`ifdef I2S_TX_ROUND_EN
  localparam int RND_SH = (OUT_W < I2S_SLOT_W) ? I2S_SLOT_W - 1 - OUT_W : 0;

  function automatic logic [OUT_W-1:0] round_word(input sample_t s);
    logic [32:0] sum;
    if (OUT_W == I2S_SLOT_W) return s[31 -: OUT_W];
    sum = {s[31], s} + (33'd1 << RND_SH);
    // Only a non-negative input can carry into the sign bit.
    if (!s[31] && sum[31]) return {1'b0, {(OUT_W-1){1'b1}}};
    return sum[31 -: OUT_W];
  endfunction

  logic [OUT_W-1:0] round_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) round_q <= '0;
    else        round_q <= round_word(hold);
  end

  assign word = round_q;
`else
  logic unused_hold;
  assign unused_hold = ^hold;
  assign word        = hold[31 -: OUT_W];
`endif

  assign slot  = I2S_SLOT_W'(word) << (I2S_SLOT_W - OUT_W);
  assign frame = {slot, slot};

  // bit_idx is the index n that the next sclk falling edge will start.
  // Bits are presented on sclk falls and the shifter advances on the following rise.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bit_idx   <= '0;
      hold      <= '0;
      shreg     <= '0;
      step_out  <= 1'b0;
      lrclk_out <= 1'b0;
      sdata_out <= 1'b0;
    end else begin
      step_out <= 1'b0;
      if (sclk_rise) shreg <= shreg << 1;
      if (sclk_fall) begin
        bit_idx   <= bit_idx + IDX_W'(1);
        lrclk_out <= (bit_idx >= IDX_W'(I2S_SLOT_W));
        if (bit_idx == '0) begin
          step_out  <= 1'b1;
          hold      <= sample_in;
          sdata_out <= shreg[I2S_FRAME_BITS-1];
        end else if (bit_idx == IDX_W'(1)) begin
          shreg     <= frame;
          sdata_out <= frame[I2S_FRAME_BITS-1];
        end else begin
          sdata_out <= shreg[I2S_FRAME_BITS-1];
        end
      end
    end
  end
endmodule
